// File: rtl/store_align_unit.sv
// rtl/store_align_unit.sv - store request to byte-lane-aligned memory write beats
//
// Purpose: converts an LSU store (address, rs2 data, funct3 SB/SH/SW) into one
// or two word-addressed write beats with byte enables. A store that crosses a
// 32-bit word boundary is split into two back-to-back beats.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   req_valid/req_ready request handshake (ready only in IDLE)
//   req_addr/req_data   byte address and rs2 value
//   req_type            funct3: 000 SB, 001 SH, 010 SW, others illegal
//   mem_valid/mem_ready write beat handshake
//   mem_addr            word-aligned beat address
//   mem_wdata/mem_bmask lane-aligned data and byte enables (bit i = lane i)
//   done/err            one-cycle retire pulse; err marks a rejected request

module store_align_unit #(
  parameter bit ALLOW_MISALIGNED = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_data,
  input  logic [2:0]  req_type,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_bmask,
  output logic        done,
  output logic        err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BEAT0 = 2'd1,
    S_BEAT1 = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic        rej_q;
  logic        split_q;
  logic [31:0] b1_addr_q;
  logic [31:0] b1_wdata_q;
  logic [3:0]  b1_bmask_q;

  logic        mem_valid_q;
  logic [31:0] mem_addr_q;
  logic [31:0] mem_wdata_q;
  logic [3:0]  mem_bmask_q;

  // Request decode, evaluated on the live inputs and captured at accept.
  logic [1:0]  off;
  logic [7:0]  base_mask;
  logic [31:0] trunc_data;
  logic        type_ok;
  logic        misal;
  logic [7:0]  req_mask;
  logic [63:0] req_d64;
  logic        req_reject;
  logic        req_split;
  logic [31:0] beat0_addr;
  logic [31:0] beat1_addr;

  assign off = req_addr[1:0];

  always_comb begin
    base_mask  = 8'h00;
    trunc_data = 32'h0;
    type_ok    = 1'b1;
    misal      = 1'b0;
    case (req_type)
      3'b000: begin
        base_mask  = 8'h01;
        trunc_data = {24'h0, req_data[7:0]};
      end
      3'b001: begin
        base_mask  = 8'h03;
        trunc_data = {16'h0, req_data[15:0]};
        misal      = off[0];
      end
      3'b010: begin
        base_mask  = 8'h0F;
        trunc_data = req_data;
        misal      = (off != 2'b00);
      end
      default: type_ok = 1'b0;
    endcase
  end

  // Mask and data are built in a 64-bit (two-word) window; the upper word
  // becomes the second beat when the store crosses the word boundary.
  assign req_mask   = base_mask << off;
  assign req_d64    = {32'h0, trunc_data} << {off, 3'b000};
  assign req_reject = !type_ok || (!ALLOW_MISALIGNED && misal);
  assign req_split  = (req_mask[7:4] != 4'h0);
  assign beat0_addr = {req_addr[31:2], 2'b00};
  assign beat1_addr = beat0_addr + 32'd4;  // wraps past 0xFFFFFFFC

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (req_valid) state_d = req_reject ? S_RESP : S_BEAT0;
      S_BEAT0: if (mem_ready) state_d = split_q ? S_BEAT1 : S_RESP;
      S_BEAT1: if (mem_ready) state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    req_ready = (state_q == S_IDLE);
    done      = (state_q == S_RESP);
    err       = (state_q == S_RESP) && rej_q;
  end

  assign mem_valid = mem_valid_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_bmask = mem_bmask_q;

  // Beat registers: loaded at accept, swapped to the second beat when the
  // first completes, so the bus sees stable values across any stall.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rej_q       <= 1'b0;
      split_q     <= 1'b0;
      b1_addr_q   <= 32'h0;
      b1_wdata_q  <= 32'h0;
      b1_bmask_q  <= 4'h0;
      mem_valid_q <= 1'b0;
      mem_addr_q  <= 32'h0;
      mem_wdata_q <= 32'h0;
      mem_bmask_q <= 4'h0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            rej_q      <= req_reject;
            split_q    <= req_split;
            b1_addr_q  <= beat1_addr;
            b1_wdata_q <= req_d64[63:32];
            b1_bmask_q <= req_mask[7:4];
            if (!req_reject) begin
              mem_valid_q <= 1'b1;
              mem_addr_q  <= beat0_addr;
              mem_wdata_q <= req_d64[31:0];
              mem_bmask_q <= req_mask[3:0];
            end
          end
        end
        S_BEAT0: begin
          if (mem_ready) begin
            if (split_q) begin
              mem_addr_q  <= b1_addr_q;
              mem_wdata_q <= b1_wdata_q;
              mem_bmask_q <= b1_bmask_q;
            end else begin
              mem_valid_q <= 1'b0;
            end
          end
        end
        S_BEAT1: begin
          if (mem_ready) mem_valid_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_store_align_unit.sv
// tb/tb_store_align_unit.sv - directed self-checking bench for store_align_unit

module tb_store_align_unit;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_valid1;
  logic [31:0] req_addr;
  logic [31:0] req_data;
  logic [2:0]  req_type;
  logic        mem_ready;

  logic        req_ready, mem_valid, done, err;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_bmask;

  logic        req_ready1, mem_valid1, done1, err1;
  logic [31:0] mem_addr1, mem_wdata1;
  logic [3:0]  mem_bmask1;

  int total;
  int passed;

  store_align_unit #(.ALLOW_MISALIGNED(1'b1)) u0 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data), .req_type(req_type),
    .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_bmask(mem_bmask),
    .done(done), .err(err)
  );

  store_align_unit #(.ALLOW_MISALIGNED(1'b0)) u1 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid1), .req_ready(req_ready1),
    .req_addr(req_addr), .req_data(req_data), .req_type(req_type),
    .mem_valid(mem_valid1), .mem_ready(mem_ready),
    .mem_addr(mem_addr1), .mem_wdata(mem_wdata1), .mem_bmask(mem_bmask1),
    .done(done1), .err(err1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic beat(input string tag, input logic [31:0] a, input logic [3:0] m,
                      input logic [31:0] d);
    chk({tag, " valid"}, {31'h0, mem_valid}, 32'd1);
    chk({tag, " addr"},  mem_addr, a);
    chk({tag, " bmask"}, {28'h0, mem_bmask}, {28'h0, m});
    chk({tag, " wdata"}, mem_wdata, d);
    chk({tag, " done"},  {31'h0, done}, 32'd0);
  endtask

  // Raise a request, let the next edge accept it, then drop req_valid.
  task automatic issue(input logic [31:0] a, input logic [31:0] d, input logic [2:0] t);
    req_addr  = a;
    req_data  = d;
    req_type  = t;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
  endtask

  initial begin
    total      = 0;
    passed     = 0;
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_valid1 = 1'b0;
    req_addr   = 32'h0;
    req_data   = 32'h0;
    req_type   = 3'b000;
    mem_ready  = 1'b1;
    tick();
    tick();

    // Reset state
    chk("rst mem_valid", {31'h0, mem_valid}, 32'd0);
    chk("rst mem_addr",  mem_addr, 32'h0);
    chk("rst mem_wdata", mem_wdata, 32'h0);
    chk("rst mem_bmask", {28'h0, mem_bmask}, 32'h0);
    chk("rst done",      {31'h0, done}, 32'd0);
    chk("rst err",       {31'h0, err}, 32'd0);
    chk("rst req_ready", {31'h0, req_ready}, 32'd1);
    rst_n = 1'b1;
    tick();

    // SB at byte 2: single beat, done two cycles after accept
    issue(32'h0000_1002, 32'hAABB_CCDD, 3'b000);
    beat("sb b0", 32'h0000_1000, 4'b0100, 32'h00DD_0000);
    chk("sb req_ready busy", {31'h0, req_ready}, 32'd0);
    tick();
    chk("sb done", {31'h0, done}, 32'd1);
    chk("sb err",  {31'h0, err}, 32'd0);
    chk("sb valid off", {31'h0, mem_valid}, 32'd0);
    tick();
    chk("sb done pulse", {31'h0, done}, 32'd0);
    chk("sb req_ready", {31'h0, req_ready}, 32'd1);

    // SW offset 1: split across words
    issue(32'h0000_2001, 32'h1122_3344, 3'b010);
    beat("sw b0", 32'h0000_2000, 4'b1110, 32'h2233_4400);
    tick();
    beat("sw b1", 32'h0000_2004, 4'b0001, 32'h0000_0011);
    tick();
    chk("sw done", {31'h0, done}, 32'd1);
    chk("sw err",  {31'h0, err}, 32'd0);
    chk("sw valid off", {31'h0, mem_valid}, 32'd0);
    tick();
    chk("sw done pulse", {31'h0, done}, 32'd0);

    // SH at the top of the address space: beat1 address wraps to zero
    issue(32'hFFFF_FFFF, 32'h0000_BEEF, 3'b001);
    beat("sh b0", 32'hFFFF_FFFC, 4'b1000, 32'hEF00_0000);
    tick();
    beat("sh b1", 32'h0000_0000, 4'b0001, 32'h0000_00BE);
    tick();
    chk("sh done", {31'h0, done}, 32'd1);
    tick();

    // Aligned SW with memory stalled for three cycles; competing request ignored
    mem_ready = 1'b0;
    issue(32'h0000_4000, 32'hCAFE_F00D, 3'b010);
    beat("stall b0", 32'h0000_4000, 4'b1111, 32'hCAFE_F00D);
    req_addr  = 32'h0000_5000;
    req_data  = 32'h1234_5678;
    req_type  = 3'b000;
    req_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      beat("stall hold", 32'h0000_4000, 4'b1111, 32'hCAFE_F00D);
      chk("stall req_ready", {31'h0, req_ready}, 32'd0);
    end
    mem_ready = 1'b1;
    req_valid = 1'b0;
    tick();
    chk("stall done", {31'h0, done}, 32'd1);
    chk("stall valid off", {31'h0, mem_valid}, 32'd0);
    tick();
    chk("stall single done", {31'h0, done}, 32'd0);
    chk("stall no new beat", {31'h0, mem_valid}, 32'd0);
    chk("stall req_ready", {31'h0, req_ready}, 32'd1);

    // Illegal type: rejected, done+err the cycle after accept
    issue(32'h0000_0000, 32'hFFFF_FFFF, 3'b011);
    chk("ill done",  {31'h0, done}, 32'd1);
    chk("ill err",   {31'h0, err}, 32'd1);
    chk("ill valid", {31'h0, mem_valid}, 32'd0);
    tick();
    chk("ill done pulse", {31'h0, done}, 32'd0);
    chk("ill err pulse",  {31'h0, err}, 32'd0);

    // Misaligned SW on the ALLOW_MISALIGNED=0 instance
    req_addr   = 32'h0000_3002;
    req_data   = 32'h5566_7788;
    req_type   = 3'b010;
    req_valid1 = 1'b1;
    tick();
    req_valid1 = 1'b0;
    chk("nomis done",  {31'h0, done1}, 32'd1);
    chk("nomis err",   {31'h0, err1}, 32'd1);
    chk("nomis valid", {31'h0, mem_valid1}, 32'd0);
    tick();
    chk("nomis done pulse", {31'h0, done1}, 32'd0);
    chk("nomis valid2", {31'h0, mem_valid1}, 32'd0);

    // Reset while in BEAT1
    issue(32'h0000_6003, 32'hDEAD_BEEF, 3'b010);
    beat("rstb b0", 32'h0000_6000, 4'b1000, 32'hEF00_0000);
    tick();
    beat("rstb b1", 32'h0000_6004, 4'b0111, 32'h00DE_ADBE);
    rst_n = 1'b0;
    tick();
    chk("rstb valid", {31'h0, mem_valid}, 32'd0);
    chk("rstb done",  {31'h0, done}, 32'd0);
    chk("rstb bmask", {28'h0, mem_bmask}, 32'h0);
    rst_n = 1'b1;
    tick();
    chk("rstb req_ready", {31'h0, req_ready}, 32'd1);
    chk("rstb done2", {31'h0, done}, 32'd0);

    // Aligned SW after reset completes normally
    issue(32'h0000_7000, 32'h0102_0304, 3'b010);
    beat("post b0", 32'h0000_7000, 4'b1111, 32'h0102_0304);
    tick();
    chk("post done", {31'h0, done}, 32'd1);
    chk("post err",  {31'h0, err}, 32'd0);
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
